// File: rtl/prog_readback.sv
// Read-back stepper for the 256x16 program RAM: each enter press shows the next
// byte of the program on the LEDs, high byte first, then low byte, then the next word.
module prog_readback #(
    parameter int unsigned RD_LAT    = 1,
    parameter logic [7:0]  LAST_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter,
    input  logic [15:0] dataRd,
    output logic [7:0]  addrRd,
    output logic        rdEn,
    output logic [7:0]  leds,
    output logic        byteHi,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_HI,
        S_LO
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_t      state_q;
    logic        enter_d_q;
    logic [7:0]  addr_q;
    logic        rd_en_q;
    logic [7:0]  leds_q;
    logic        byte_hi_q;
    logic        busy_q;
    logic [7:0]  word_lo_q;
    logic [1:0]  cnt_q;

    logic        enter_pos;
    logic [7:0]  addr_d;

    assign enter_pos = enter & ~enter_d_q;

    // Explicit compare so a LAST_ADDR below 8'hFF still wraps to zero.
    assign addr_d = (addr_q == LAST_ADDR) ? 8'h00 : addr_q + 8'h01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            enter_d_q <= 1'b0;
            addr_q    <= 8'h00;
            rd_en_q   <= 1'b0;
            leds_q    <= 8'h00;
            byte_hi_q <= 1'b0;
            busy_q    <= 1'b0;
            word_lo_q <= 8'h00;
            cnt_q     <= 2'd0;
        end else begin
            enter_d_q <= enter;
            rd_en_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    leds_q <= 8'h00;
                    if (enter_pos) begin
                        state_q <= S_READ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                    cnt_q   <= LAT_INIT;
                end
                S_WAIT: begin
                    // Last count is the cycle in which the RAM presents valid data.
                    if (cnt_q <= 2'd1) begin
                        word_lo_q <= dataRd[7:0];
                        leds_q    <= dataRd[15:8];
                        byte_hi_q <= 1'b1;
                        busy_q    <= 1'b0;
                        cnt_q     <= 2'd0;
                        state_q   <= S_HI;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_HI: begin
                    if (enter_pos) begin
                        leds_q    <= word_lo_q;
                        byte_hi_q <= 1'b0;
                        state_q   <= S_LO;
                    end
                end
                S_LO: begin
                    if (enter_pos) begin
                        addr_q  <= addr_d;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign addrRd = addr_q;
    assign rdEn   = rd_en_q;
    assign leds   = leds_q;
    assign byteHi = byte_hi_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_prog_readback.sv
// Directed bench for prog_readback: three instances (default, LAST_ADDR=3, RD_LAT=3)
// each backed by a behavioural RAM that shows garbage outside its valid-data cycle.
module tb_prog_readback;

    logic        clk;
    logic        rst;
    logic        enter  [3];
    logic [15:0] dr     [3];
    logic [7:0]  addr   [3];
    logic        rden   [3];
    logic [7:0]  leds   [3];
    logic        bhi    [3];
    logic        busy   [3];

    logic [15:0] ram    [3][256];
    logic        v      [3][3];
    logic [7:0]  pa     [3][3];
    logic [15:0] garb;
    int          rcnt   [3];

    int          checks = 0;
    int          errors = 0;

    prog_readback u_def (
        .clk(clk), .rst(rst), .enter(enter[0]), .dataRd(dr[0]),
        .addrRd(addr[0]), .rdEn(rden[0]), .leds(leds[0]), .byteHi(bhi[0]), .busy(busy[0])
    );

    prog_readback #(.RD_LAT(1), .LAST_ADDR(8'h03)) u_wrap3 (
        .clk(clk), .rst(rst), .enter(enter[1]), .dataRd(dr[1]),
        .addrRd(addr[1]), .rdEn(rden[1]), .leds(leds[1]), .byteHi(bhi[1]), .busy(busy[1])
    );

    prog_readback #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .enter(enter[2]), .dataRd(dr[2]),
        .addrRd(addr[2]), .rdEn(rden[2]), .leds(leds[2]), .byteHi(bhi[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    // RAM model: the word addressed in the rdEn cycle is valid exactly RD_LAT cycles later.
    always @(posedge clk) begin
        garb <= 16'($urandom());
        for (int i = 0; i < 3; i++) begin
            v[i][0]  <= rden[i];
            pa[i][0] <= addr[i];
            for (int j = 1; j < 3; j++) begin
                v[i][j]  <= v[i][j-1];
                pa[i][j] <= pa[i][j-1];
            end
            if (rden[i]) rcnt[i] <= rcnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dr[i] = garb;
            if (v[i][lat_of(i)-1]) dr[i] = ram[i][pa[i][lat_of(i)-1]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        enter[i] = 1'b1;
        tick();
        enter[i] = 1'b0;
        tick();
    endtask

    task automatic wait_hi(input int i, input string tag);
        int n;
        n = 0;
        while (!bhi[i] && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(bhi[i]), 32'd1);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        garb = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            enter[i] = 1'b0;
            rcnt[i]  = 0;
            for (int j = 0; j < 3; j++) begin
                v[i][j]  = 1'b0;
                pa[i][j] = 8'h00;
            end
        end
        for (int a = 0; a < 256; a++) begin
            ram[0][a] = {8'(a) ^ 8'hC3, ~8'(a)};
            ram[1][a] = {8'(a) ^ 8'h5A, 8'(a)};
            ram[2][a] = 16'h0F0F;
        end
        ram[0][0] = 16'hA55A;
        ram[0][1] = 16'h1234;
        ram[2][0] = 16'hBEEF;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_addr", 32'(addr[0]), 32'h0);
        check("rst_rden", 32'(rden[0]), 32'h0);
        check("rst_leds", 32'(leds[0]), 32'h0);
        check("rst_bhi",  32'(bhi[0]),  32'h0);
        check("rst_busy", 32'(busy[0]), 32'h0);

        // First read: press in cycle N, rdEn in N+1, high byte at N+3.
        enter[0] = 1'b1;
        tick();
        check("p1_rden_n1", 32'(rden[0]), 32'h1);
        check("p1_addr_n1", 32'(addr[0]), 32'h0);
        check("p1_busy_n1", 32'(busy[0]), 32'h1);
        enter[0] = 1'b0;
        tick();
        check("p1_rden_n2", 32'(rden[0]), 32'h0);
        check("p1_busy_n2", 32'(busy[0]), 32'h1);
        check("p1_leds_n2", 32'(leds[0]), 32'h0);
        tick();
        check("p1_leds_n3", 32'(leds[0]), 32'hA5);
        check("p1_bhi_n3",  32'(bhi[0]),  32'h1);
        check("p1_busy_n3", 32'(busy[0]), 32'h0);

        enter[0] = 1'b1;
        tick();
        check("p2_leds", 32'(leds[0]), 32'h5A);
        check("p2_bhi",  32'(bhi[0]),  32'h0);
        enter[0] = 1'b0;
        tick();
        enter[0] = 1'b1;
        tick();
        check("p3_rden", 32'(rden[0]), 32'h1);
        check("p3_addr", 32'(addr[0]), 32'h1);
        enter[0] = 1'b0;
        tick();
        check("p3_rden_off", 32'(rden[0]), 32'h0);
        tick();
        check("p3_leds", 32'(leds[0]), 32'h12);
        check("p3_rcnt", 32'(rcnt[0]), 32'd2);

        // Held button: exactly one advance.
        c = rcnt[0];
        enter[0] = 1'b1;
        repeat (20) tick();
        check("hold_leds", 32'(leds[0]), 32'h34);
        check("hold_bhi",  32'(bhi[0]),  32'h0);
        check("hold_addr", 32'(addr[0]), 32'h1);
        enter[0] = 1'b0;
        tick();
        check("hold_rcnt", 32'(rcnt[c == 0 ? 0 : 0]) - 32'(c), 32'd0);

        // RD_LAT=3 with presses while busy and garbage on dataRd.
        enter[2] = 1'b1;
        tick();
        check("l3_rden_n1", 32'(rden[2]), 32'h1);
        enter[2] = 1'b0;
        tick();
        check("l3_leds_n2", 32'(leds[2]), 32'h0);
        check("l3_busy_n2", 32'(busy[2]), 32'h1);
        enter[2] = 1'b1;
        tick();
        check("l3_leds_n3", 32'(leds[2]), 32'h0);
        check("l3_rden_n3", 32'(rden[2]), 32'h0);
        enter[2] = 1'b0;
        tick();
        check("l3_leds_n4", 32'(leds[2]), 32'h0);
        check("l3_busy_n4", 32'(busy[2]), 32'h1);
        enter[2] = 1'b1;
        tick();
        check("l3_leds_n5", 32'(leds[2]), 32'hBE);
        check("l3_bhi_n5",  32'(bhi[2]),  32'h1);
        check("l3_busy_n5", 32'(busy[2]), 32'h0);
        check("l3_addr_n5", 32'(addr[2]), 32'h0);
        enter[2] = 1'b0;
        tick();
        tick();
        check("l3_not_queued", 32'(leds[2]), 32'hBE);
        check("l3_rcnt", 32'(rcnt[2]), 32'd1);

        // LAST_ADDR=3 visits 0,1,2,3,0.
        press(1);
        wait_hi(1, "w3_a0");
        check("w3_addr0", 32'(addr[1]), 32'h0);
        check("w3_leds0", 32'(leds[1]), 32'h5A);
        for (int k = 1; k <= 4; k++) begin
            press(1);
            press(1);
            wait_hi(1, "w3_step");
            check("w3_addr", 32'(addr[1]), 32'(k % 4));
            check("w3_leds", 32'(leds[1]), 32'(8'(k % 4) ^ 8'h5A));
        end

        // Default instance: walk the whole RAM, address after 8'hFF is 8'h00.
        for (int k = 2; k <= 256; k++) begin
            press(0);
            wait_hi(0, "full");
            check("full_addr", 32'(addr[0]), 32'(k % 256));
            check("full_leds", 32'(leds[0]), 32'(ram[0][k % 256][15:8]));
            if (k != 256) press(0);
        end

        // Reset in WAIT clears outputs without a clock edge.
        press(0);
        check("rw_leds_lo", 32'(leds[0]), 32'h5A);
        enter[0] = 1'b1;
        tick();
        enter[0] = 1'b0;
        tick();
        check("rw_busy",  32'(busy[0]), 32'h1);
        check("rw_addr1", 32'(addr[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("ar_addr", 32'(addr[0]), 32'h0);
        check("ar_leds", 32'(leds[0]), 32'h0);
        check("ar_bhi",  32'(bhi[0]),  32'h0);
        check("ar_busy", 32'(busy[0]), 32'h0);
        check("ar_rden", 32'(rden[0]), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        press(0);
        wait_hi(0, "post_rst");
        check("post_rst_addr", 32'(addr[0]), 32'h0);
        check("post_rst_leds", 32'(leds[0]), 32'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_readback.md
Name: prog_readback

Overview:
- Read-back companion to the switch-programming writer: steps through the 256x16 program RAM and shows each 16-bit word on the 8 LEDs, one byte at a time.
- Each operator `enter` press advances the display: high byte first, then low byte, then the next address.
- Drives the RAM read port (address, read enable) and captures read data after a fixed read latency.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from the rdEn cycle to valid dataRd (legal 1..3).
- LAST_ADDR, 8'hFF, highest address visited; the address after it wraps to 0.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- enter  input  1  operator step button, level; internally edge-detected
- dataRd  input  16  RAM read data
- addrRd  output  8  RAM read address
- rdEn  output  1  RAM read enable, one-cycle pulse
- leds  output  8  displayed byte
- byteHi  output  1  1 = leds shows high byte, 0 = low byte or nothing shown
- busy  output  1  1 while a read is outstanding (READ or WAIT)

Behaviour:
- Interface is fixed: one clock, clk; reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: addrRd=0, rdEn=0, leds=0, byteHi=0, busy=0, state=IDLE, internal enter delay register=0, captured word=0, latency counter=0.
- Edge detect: enter_pos = enter & ~enterD, where enterD is enter delayed one cycle. A held button gives exactly one pulse.
- IDLE:
  - leds=0.
  - enter_pos -> READ. The first press after reset reads address 0.
- READ (exactly 1 cycle):
  - rdEn=1, busy=1, addrRd stable.
  - Next state is WAIT and the counter is loaded with RD_LAT.
- WAIT:
  - rdEn=0, busy=1.
  - The counter decrements each cycle. In the cycle where dataRd is valid (RD_LAT cycles after the rdEn cycle), dataRd is captured into the word register.
  - On that capture: leds=dataRd[15:8], byteHi=1, busy=0, next state HI.
- HI: enter_pos -> leds=word[7:0], byteHi=0, next state LO.
- LO: enter_pos -> next state READ, with addrRd = (addrRd==LAST_ADDR) ? 0 : addrRd+1.
- Latency: if enter_pos is high in cycle N (in IDLE or LO), rdEn is high in cycle N+1 and the high byte appears on leds in cycle N+2+RD_LAT.
- enter_pos during READ or WAIT is ignored: it is not queued and does not affect the counter.
- addrRd changes only on the LO->READ transition. It never changes while rdEn=1 or during WAIT.
- Wrap: with LAST_ADDR=8'hFF, the increment is 8-bit modulo. For a smaller LAST_ADDR, an explicit compare wraps to 0.
- Reset asserted mid-operation (any state, including during WAIT) forces all reset values immediately and asynchronously. A pending read result is discarded.
- dataRd is sampled only in the capture cycle. Changes at any other time have no effect on leds.
- No write port. The block never drives a RAM write.

Test Plan:
- Reset, then preload RAM[0]=16'hA55A. Single enter press at cycle N -> rdEn=1 only in N+1 with addrRd=0; with RD_LAT=1, leds=8'hA5 and byteHi=1 at N+3.
- Continuing from the previous case, second press -> leds=8'h5A, byteHi=0. Third press with RAM[1]=16'h1234 -> addrRd=1, one rdEn pulse, then leds=8'h12.
- Hold enter high for 20 cycles in HI -> exactly one advance (leds goes 8'hA5 -> 8'h5A only). Presses issued while busy=1 -> no state or address change and no extra rdEn.
- Set LAST_ADDR=8'h03 and step through all words -> addresses read in order 0,1,2,3,0. With the default parameter, the address after 8'hFF is 8'h00.
- RD_LAT=3, RAM[0]=16'hBEEF -> dataRd captured 3 cycles after rdEn; leds=8'hBE at N+5. Garbage driven on dataRd before the capture cycle does not appear on leds.
- Assert rst during WAIT -> addrRd, leds, byteHi, busy and rdEn go to 0 without waiting for a clock edge. The next enter after release restarts a read at address 0.
